uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised UART transmitter for the serial TX path.
- Serialises one word per frame (start, data LSB-first, optional parity, 1 or 2 stop bits) at a fixed clocks-per-bit rate.
- Accepts words on a valid/ready handshake. A one-entry holding buffer allows back-to-back frames with no idle gap.
- Replaces the fixed 8N1 transmitter. Adds parity, stop-bit count and flow control.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9
CLK_DIV, 16, clk cycles per serial bit; legal >= 2
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; legal 1 or 2

Ports:
clk  input  1  system clock, rising edge
arst  input  1  asynchronous reset, active-high
tx_valid  input  1  tx_data valid for transfer
tx_data  input  DATA_WIDTH  word to send
tx_ready  output  1  holding buffer empty; word accepted on edge where tx_valid & tx_ready
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress, registered
done  output  1  one-cycle pulse at end of each frame, registered

Behaviour:
- Reset (arst high, async) sets:
  - tx=1, busy=0, done=0, tx_ready=1.
  - FSM=IDLE, buffer empty, bit and clock counters 0.
  - Applies immediately, including mid-frame. A frame aborted by reset produces no done pulse.
- Handshake:
  - tx_ready = NOT buffer_full, driven from a register.
  - A word is accepted on a rising edge with tx_valid=1 and tx_ready=1. tx_data is captured on that edge.
  - tx_data changes before or after acceptance have no effect on the captured word.
  - tx_valid while tx_ready=0 is ignored; the source holds it.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0.
  - If the buffer is full: load the shifter from the buffer, clear the buffer, go to START.
  - Latency: accept at edge E; buffer-to-shifter transfer at edge E+1; tx=0 and busy=1 visible after edge E+1.
- Bit timing:
  - Every bit holds tx for exactly CLK_DIV cycles, using a clock counter 0..CLK_DIV-1.
  - The state or bit advances on the edge where the counter equals CLK_DIV-1. The counter then wraps to 0.
- START: tx=0 for one bit, then DATA.
- DATA:
  - tx = shifter[0]; the shifter shifts right each bit (LSB first).
  - Bit index runs 0..DATA_WIDTH-1.
  - After the last data bit: go to PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - tx = XOR of the captured word, inverted when PARITY_ODD=1.
  - Computed from the captured copy, not from the live tx_data.
- STOP:
  - tx=1 for STOP_BITS bits.
  - At the end of the last stop bit, done=1 for the next cycle only.
  - If the buffer is full on that same edge: reload the shifter, clear the buffer, go directly to START. No idle gap; busy stays 1.
  - Otherwise go to IDLE with busy=0.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLK_DIV cycles.
- Buffer:
  - May be written during any state while empty.
  - Accept and buffer drain never coincide, because accept requires the buffer empty.
  - tx_ready returns to 1 on the edge the buffer drains.
- Counter widths: clock counter is clog2(CLK_DIV) bits; bit index is clog2(DATA_WIDTH+1) bits. No overflow is possible within legal parameters.

Test Plan:
- Defaults, send 0xA5 from idle:
  - tx bits 0,1,0,1,0,0,1,0,1,1, each 16 cycles.
  - busy high 160 cycles; single done pulse at cycle 160 after tx falls.
  - tx_ready low for exactly 1 cycle after accept.
- Back-to-back, defaults: 0x00 then 0xFF with tx_valid held.
  - 0xFF accepted 2 cycles after 0x00.
  - tx_ready stays low until frame 1 ends.
  - Frame 2 start bit immediately follows frame 1 stop bit; busy never drops.
  - Two done pulses 160 cycles apart.
- PARITY_EN=1, data 0x07:
  - PARITY_ODD=0 gives parity bit 1; PARITY_ODD=1 gives 0.
  - Frame 176 cycles.
  - Changing tx_data after accept does not alter parity.
- STOP_BITS=2, data 0x3C: tx high 32 cycles after bit 7; done at cycle 176.
- arst pulsed mid-frame during data bit 3:
  - tx=1, busy=0, tx_ready=1 without waiting for a clock edge.
  - No done pulse.
  - Following send of 0x5A frames correctly.
- Flow control: third word presented while frame 1 is active and buffer full → not accepted until frame 1 ends; word presented while not ready is never sent twice.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// A one-word holding buffer in front of the shifter lets frames run back to back.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    tx_ready_q;
  logic                    tx_q;
  logic                    busy_q;
  logic                    done_q;

  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;

  logic                    bit_end;
  logic                    stop_end;
  logic                    accept;
  logic                    load;
  logic                    shift;

  // tx_ready_q doubles as the "holding buffer empty" flag.
  always_comb begin
    bit_end  = (cnt_q == CNT_LAST);
    stop_end = (state_q == S_STOP) && bit_end && (idx_q == STOP_LAST);
    accept   = tx_valid && tx_ready_q;
    load     = !tx_ready_q && ((state_q == S_IDLE) || stop_end);
    shift    = (state_q == S_DATA) && bit_end;
  end

  always_comb begin
    hold_d  = accept ? tx_data : hold_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (load) begin
      shift_d = hold_q;
      par_d   = (^hold_q) ^ PAR_INV;
    end else if (shift) begin
      shift_d = shift_q >> 1;
    end
  end

  // Data registers carry no reset; they are only read after a load.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_ready_q <= 1'b1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        tx_ready_q <= 1'b0;
      end else if (load) begin
        tx_ready_q <= 1'b1;
      end

      if (state_q != S_IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (load) begin
            state_q <= S_START;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end

        // shift_q moves on this same edge, so the next bit is shift_q[1].
        S_DATA: begin
          if (bit_end) begin
            if (idx_q == DATA_LAST) begin
              idx_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
              tx_q  <= shift_q[1];
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            idx_q   <= '0;
            tx_q    <= 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (stop_end) begin
              done_q <= 1'b1;
              idx_q  <= '0;
              if (load) begin
                state_q <= S_START;
                tx_q    <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four parameter variants checked every cycle against a
// frame-level model, plus directed frame vectors and multi-cycle corner sequences.
module tb_uart_tx_frame;

  localparam int CD = 16;
  localparam int ND = 4;
  localparam int NV = 8;
  localparam int PE_T [ND] = '{0, 1, 1, 0};
  localparam int PO_T [ND] = '{0, 0, 1, 0};
  localparam int SB_T [ND] = '{1, 1, 1, 2};

  logic          clk = 1'b0;
  logic          arst;
  logic [ND-1:0] vld;
  logic [7:0]    din [ND];
  wire  [ND-1:0] rdy_w, tx_w, busy_w, done_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    uart_tx_frame #(
      .DATA_WIDTH(8),
      .CLK_DIV   (CD),
      .PARITY_EN (PE_T[g]),
      .PARITY_ODD(PO_T[g]),
      .STOP_BITS (SB_T[g])
    ) u_dut (
      .clk     (clk),
      .arst    (arst),
      .tx_valid(vld[g]),
      .tx_data (din[g]),
      .tx_ready(rdy_w[g]),
      .tx      (tx_w[g]),
      .busy    (busy_w[g]),
      .done    (done_w[g])
    );
  end

  // Reference model: a frame is a bit pattern plus elapsed cycles into it.
  logic [11:0] m_frm  [ND];
  int          m_len  [ND];
  int          m_t    [ND];
  bit          m_full [ND];
  logic [7:0]  m_buf  [ND];
  bit          m_done [ND];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [11:0] bits;
    int          nb;
    int          len;
  } vec_t;

  vec_t vec [NV];

  function automatic logic [11:0] frame_bits(int d, logic [7:0] w);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = w[i];
    if (PE_T[d] != 0) f[9] = (^w) ^ (PO_T[d] != 0);
    return f;
  endfunction

  function automatic int frame_nbits(int d);
    return 1 + 8 + PE_T[d] + SB_T[d];
  endfunction

  function automatic int exp_vec(int d);
    logic e_tx;
    e_tx = (m_len[d] != 0) ? m_frm[d][m_t[d] / CD] : 1'b1;
    return int'({e_tx, (m_len[d] != 0), m_done[d], !m_full[d]});
  endfunction

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      m_frm[d]  = '1;
      m_len[d]  = 0;
      m_t[d]    = 0;
      m_full[d] = 1'b0;
      m_buf[d]  = '0;
      m_done[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (arst) begin
      model_clear();
    end else begin
      for (int d = 0; d < ND; d++) begin
        bit acc;
        acc       = vld[d] && !m_full[d];
        m_done[d] = 1'b0;
        if (m_len[d] != 0) begin
          m_t[d]++;
          if (m_t[d] == m_len[d]) begin
            m_done[d] = 1'b1;
            m_len[d]  = 0;
            m_t[d]    = 0;
          end
        end
        if (m_len[d] == 0 && m_full[d]) begin
          m_frm[d]  = frame_bits(d, m_buf[d]);
          m_len[d]  = frame_nbits(d) * CD;
          m_t[d]    = 0;
          m_full[d] = 1'b0;
        end
        if (acc) begin
          m_buf[d]  = din[d];
          m_full[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < ND; d++)
      chk($sformatf("cycle_dut%0d{tx,busy,done,ready}", d),
          int'({tx_w[d], busy_w[d], done_w[d], rdy_w[d]}), exp_vec(d));
  endtask

  task automatic send_frame(input int d, input logic [7:0] w, input logic [11:0] eb,
                            input int nb, input int len);
    logic [11:0] got;
    int busy_n, done_at, done_n;
    bit r0, r1;
    vld[d] = 1'b1;
    din[d] = w;
    tick();
    vld[d] = 1'b0;
    din[d] = w ^ 8'h01;
    r0 = rdy_w[d];
    tick();
    r1 = rdy_w[d];
    chk($sformatf("ready_pulse_dut%0d_%02h", d, w), int'({r0, r1}), 2'b01);
    got = '0; busy_n = 0; done_at = -1; done_n = 0;
    for (int c = 0; c < len + 24; c++) begin
      if (busy_w[d]) busy_n++;
      if (done_w[d]) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if ((c % CD) == CD / 2 && (c / CD) < nb) got[c / CD] = tx_w[d];
      tick();
    end
    chk($sformatf("frame_bits_dut%0d_%02h", d, w), int'(got), int'(eb));
    chk($sformatf("busy_cycles_dut%0d_%02h", d, w), busy_n, len);
    chk($sformatf("done_at_dut%0d_%02h", d, w), done_at, len);
    chk($sformatf("done_count_dut%0d_%02h", d, w), done_n, 1);
  endtask

  task automatic back_to_back();
    int acc_t, busy_lo;
    int dn[$];
    bit r, an;
    vld[0] = 1'b1;
    din[0] = 8'h00;
    tick();
    din[0] = 8'hFF;
    tick();
    r = rdy_w[0];
    tick();
    chk("b2b_second_accept", int'({r, rdy_w[0]}), 2'b10);
    din[0]  = 8'h3C;
    acc_t   = -1;
    busy_lo = 0;
    for (int c = 0; c < 500; c++) begin
      if (c < 479 && !busy_w[0]) busy_lo++;
      if (done_w[0]) dn.push_back(c);
      if (acc_t < 0 && rdy_w[0]) acc_t = c + 1;
      an = vld[0] && !m_full[0];
      tick();
      if (an) vld[0] = 1'b0;
    end
    chk("b2b_third_accept_delay", acc_t, 160);
    chk("b2b_busy_gaps", busy_lo, 0);
    chk("b2b_done_count", dn.size(), 3);
    chk("b2b_done_first", (dn.size() > 0) ? dn[0] : -1, 159);
    chk("b2b_done_spacing", (dn.size() > 1) ? dn[1] - dn[0] : -1, 160);
  endtask

  task automatic reset_mid_frame();
    int nd;
    vld[0] = 1'b1;
    din[0] = 8'hC3;
    tick();
    vld[0] = 1'b0;
    tick();
    repeat (68) tick();
    chk("pre_arst_busy", int'(busy_w[0]), 1);
    #3 arst = 1'b1;
    #1;
    chk("arst_async{tx,busy,done,ready}",
        int'({tx_w[0], busy_w[0], done_w[0], rdy_w[0]}), 4'b1001);
    model_clear();
    #2 arst = 1'b0;
    nd = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done_w[0]) nd++;
    end
    chk("arst_no_done", nd, 0);
    send_frame(0, 8'h5A, 12'({1'b1, 8'h5A, 1'b0}), 10, 160);
  endtask

  task automatic random_phase();
    bit an [ND];
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < ND; d++) an[d] = vld[d] && !m_full[d];
      tick();
      for (int d = 0; d < ND; d++) begin
        if (!vld[d] || an[d]) begin
          vld[d] = ($urandom_range(0, 2) == 0);
          din[d] = 8'($urandom);
        end
      end
    end
    vld = '0;
    repeat (500) tick();
  endtask

  initial begin
    vec[0] = '{0, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}),        10, 160};
    vec[1] = '{1, 8'h07, 12'({1'b1, 1'b1, 8'h07, 1'b0}),  11, 176};
    vec[2] = '{2, 8'h07, 12'({1'b1, 1'b0, 8'h07, 1'b0}),  11, 176};
    vec[3] = '{3, 8'h3C, 12'({2'b11, 8'h3C, 1'b0}),       11, 176};
    vec[4] = '{1, 8'h00, 12'({1'b1, 1'b0, 8'h00, 1'b0}),  11, 176};
    vec[5] = '{2, 8'hFE, 12'({1'b1, 1'b0, 8'hFE, 1'b0}),  11, 176};
    vec[6] = '{3, 8'h81, 12'({2'b11, 8'h81, 1'b0}),       11, 176};
    vec[7] = '{0, 8'h00, 12'({1'b1, 8'h00, 1'b0}),        10, 160};

    arst = 1'b1;
    vld  = '0;
    for (int d = 0; d < ND; d++) din[d] = '0;
    model_clear();
    repeat (3) tick();
    for (int d = 0; d < ND; d++)
      chk($sformatf("reset_dut%0d{tx,busy,done,ready}", d),
          int'({tx_w[d], busy_w[d], done_w[d], rdy_w[d]}), 4'b1001);
    arst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < NV; i++)
      send_frame(vec[i].dut, vec[i].data, vec[i].bits, vec[i].nb, vec[i].len);

    back_to_back();
    reset_mid_frame();
    random_phase();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
